// File: rtl/pe_stream_scheduler.sv
// pe_stream_scheduler: sequences one PE job, streaming GLB words into the PE buffers and draining PE outputs back to GLB.
module pe_stream_scheduler #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] filter_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] psum_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [LEN_W-1:0]  filter_len,
  input  logic [LEN_W-1:0]  ifmap_len,
  input  logic [LEN_W-1:0]  psum_len,
  input  logic [LEN_W-1:0]  out_len,
  output logic              glb_ren,
  output logic [ADDR_W-1:0] glb_raddr,
  input  logic [WIDTH-1:0]  glb_rdata,
  output logic              glb_wen,
  output logic [ADDR_W-1:0] glb_waddr,
  output logic [WIDTH-1:0]  glb_wdata,
  output logic              pe_start,
  output logic              write_en_filter,
  output logic              write_en_ifmap,
  output logic              write_en_psum_buf,
  output logic [WIDTH-1:0]  filter_buffer_inp,
  output logic [WIDTH+1:0]  ifmap_buffer_inp,
  output logic [WIDTH-1:0]  psum_buffer_inp,
  input  logic              ready_filter_buf,
  input  logic              ready_ifmap_buf,
  input  logic              ready_psum_buf,
  output logic              read_en_buf,
  input  logic              pe_valid,
  input  logic [WIDTH-1:0]  pe_out,
  input  logic              pe_done,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, LD_FILT, LD_IFMAP, RUN, FIN} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_fb, r_ib, r_pb, r_ob, w_base;
  logic [LEN_W-1:0]  r_fl, r_il, r_pl, r_ol, r_idx, r_ocnt, w_len;
  logic r_pend, r_start, r_done_seen;
  logic w_go, w_rdy, w_issue, w_stream_done, w_active, w_drain;
  assign w_go   = go && (r_state == IDLE);
  assign w_len  = (r_state == LD_FILT) ? r_fl : (r_state == LD_IFMAP) ? r_il : (r_state == RUN) ? r_pl : '0;
  assign w_base = (r_state == LD_FILT) ? r_fb : (r_state == LD_IFMAP) ? r_ib : r_pb;
  assign w_rdy  = (r_state == LD_FILT) ? ready_filter_buf : (r_state == LD_IFMAP) ? ready_ifmap_buf : ready_psum_buf;
  assign w_issue       = w_rdy && !r_pend && (r_idx < w_len);
  assign w_stream_done = (r_idx == w_len) && !r_pend;
  assign w_active      = (r_state == LD_FILT) || (r_state == LD_IFMAP) || (r_state == RUN);
  assign w_drain       = w_active && pe_valid && (r_ocnt < r_ol);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_go ? LD_FILT : IDLE;
      LD_FILT:  w_next = w_stream_done ? LD_IFMAP : LD_FILT;
      LD_IFMAP: w_next = w_stream_done ? RUN : LD_IFMAP;
      RUN:      w_next = (w_stream_done && (r_ocnt == r_ol) && r_done_seen) ? FIN : RUN;
      FIN:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      {r_fb, r_ib, r_pb, r_ob} <= '0;
      {r_fl, r_il, r_pl, r_ol} <= '0;
      r_idx <= '0;
      r_ocnt <= '0;
      r_pend <= 1'b0;
      r_start <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_go;
      r_pend <= w_issue;
      if (w_go) begin
        {r_fb, r_ib, r_pb, r_ob} <= {filter_base, ifmap_base, psum_base, out_base};
        {r_fl, r_il, r_pl, r_ol} <= {filter_len, ifmap_len, psum_len, out_len};
      end
      // The fetch index restarts on every state change; transitions only happen with no read pending.
      r_idx <= (w_next != r_state) ? '0 : r_pend ? r_idx + 1'b1 : r_idx;
      r_ocnt <= w_go ? '0 : w_drain ? r_ocnt + 1'b1 : r_ocnt;
      r_done_seen <= (r_state == FIN) ? 1'b0 : (pe_done && (w_active || w_go)) ? 1'b1 : r_done_seen;
    end
  end
  assign pe_start          = r_start;
  assign busy              = (r_state != IDLE);
  assign done              = (r_state == FIN);
  assign glb_ren           = w_issue;
  assign glb_raddr         = w_issue ? w_base + ADDR_W'(r_idx) : '0;
  assign write_en_filter   = r_pend && (r_state == LD_FILT);
  assign write_en_ifmap    = r_pend && (r_state == LD_IFMAP);
  assign write_en_psum_buf = r_pend && (r_state == RUN);
  assign filter_buffer_inp = write_en_filter ? glb_rdata : '0;
  assign ifmap_buffer_inp  = write_en_ifmap ? {r_idx == '0, r_idx == r_il - LEN_W'(1), glb_rdata} : '0;
  assign psum_buffer_inp   = write_en_psum_buf ? glb_rdata : '0;
  assign read_en_buf       = w_drain;
  assign glb_wen           = w_drain;
  assign glb_waddr         = w_drain ? r_ob + ADDR_W'(r_ocnt) : '0;
  assign glb_wdata         = w_drain ? pe_out : '0;
endmodule
